// File: rtl/fifo_pkg.sv
// Shared types and constants for the banked-FIFO read side.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN0 = 2'd1,
    DRAIN1 = 2'd2
  } rd_state_e;

  localparam int unsigned BufDepth         = 2;
  localparam int unsigned DefaultDataWidth = 16;

  // Buffer entry at the default data width; the reader builds its own at DataWidth.
  typedef struct packed {
    logic                        bank;
    logic [DefaultDataWidth-1:0] data;
  } buf_entry_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output FIFO; entry0_r is always the head, so head is a plain register.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned Depth   = BufDepth,
  parameter type         entry_t = buf_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] occupancy,
  output logic       not_empty
);

  localparam logic [1:0] Full = 2'(Depth);

  entry_t     entry0_r, entry1_r;
  logic [1:0] count_r;
  logic       pop_s, push_s;

  // A pop from empty or a push into a full buffer without a pop is ignored.
  assign pop_s     = pop & (count_r != 2'd0);
  assign push_s    = push & ((count_r != Full) | pop_s);
  assign head      = entry0_r;
  assign occupancy = count_r;
  assign not_empty = (count_r != 2'd0);

  // Storage and occupancy update; entries shift toward the head on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0_r <= '0;
      entry1_r <= '0;
      count_r  <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b11: begin
          if (count_r == 2'd2) begin
            entry0_r <= entry1_r;
            entry1_r <= push_entry;
          end else begin
            entry0_r <= push_entry;
          end
        end
        2'b10: begin
          if (count_r == 2'd0) begin
            entry0_r <= push_entry;
          end else begin
            entry1_r <= push_entry;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          entry0_r <= entry1_r;
          count_r  <= count_r - 2'd1;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_bank_reader.sv
// Drains bank0 then bank1 of the banked FIFO into one valid/ready stream,
// hiding the banks' one-cycle read latency behind a two-entry buffer.
module fifo_bank_reader #(
  parameter int unsigned DataWidth  = fifo_pkg::DefaultDataWidth,
  parameter int unsigned BufDepth   = fifo_pkg::BufDepth,
  parameter int unsigned CountWidth = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bank0_empty,
  input  logic                  bank1_empty,
  input  logic [DataWidth-1:0]  bank0_data,
  input  logic [DataWidth-1:0]  bank1_data,
  output logic                  bank0_rd,
  output logic                  bank1_rd,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DataWidth-1:0]  m_data,
  output logic                  m_bank,
  output logic                  drained,
  output logic [CountWidth-1:0] word_count
);

  import fifo_pkg::*;

  typedef struct packed {
    logic                 bank;
    logic [DataWidth-1:0] data;
  } entry_t;

  rd_state_e             state_r, state_s;
  logic                  inflight_r, inflight_bank_r;
  logic                  rd0_s, rd1_s, pop_s, room_s;
  logic [1:0]            occ_s;
  logic [2:0]            pending_s;
  entry_t                push_entry_s, head_s;
  logic [CountWidth-1:0] word_count_r;

  // Room exists when the words already owed to the buffer, less this cycle's pop, leave a slot.
  assign pop_s     = m_valid & m_ready;
  assign pending_s = {1'b0, occ_s} + {2'b00, inflight_r};
  assign room_s    = (pending_s < (3'(BufDepth) + {2'b00, pop_s}));

  // Next state and read strobes; a bank is only left on a cycle with no read to it.
  always_comb begin
    state_s = state_r;
    rd0_s   = 1'b0;
    rd1_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!bank0_empty) begin
          state_s = DRAIN0;
        end else if (!bank1_empty) begin
          state_s = DRAIN1;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN0: begin
        if (bank0_empty) begin
          state_s = bank1_empty ? IDLE : DRAIN1;
        end else begin
          rd0_s   = room_s;
          state_s = DRAIN0;
        end
      end
      DRAIN1: begin
        if (bank1_empty) begin
          state_s = bank0_empty ? IDLE : DRAIN0;
        end else begin
          rd1_s   = room_s;
          state_s = DRAIN1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Capture the returning word from whichever bank was read last cycle.
  always_comb begin
    push_entry_s.bank = inflight_bank_r;
    if (inflight_bank_r) begin
      push_entry_s.data = bank1_data;
    end else begin
      push_entry_s.data = bank0_data;
    end
  end

  // State, in-flight tag and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      inflight_r      <= 1'b0;
      inflight_bank_r <= 1'b0;
      word_count_r    <= '0;
    end else begin
      state_r         <= state_s;
      inflight_r      <= rd0_s | rd1_s;
      inflight_bank_r <= rd1_s;
      if (pop_s) begin
        word_count_r <= word_count_r + CountWidth'(1);
      end
    end
  end

  rd_skid_buf #(
    .Depth   (BufDepth),
    .entry_t (entry_t)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_r),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .occupancy  (occ_s),
    .not_empty  (m_valid)
  );

  assign bank0_rd   = rd0_s;
  assign bank1_rd   = rd1_s;
  assign m_data     = head_s.data;
  assign m_bank     = head_s.bank;
  assign word_count = word_count_r;
  assign drained    = bank0_empty & bank1_empty & ~inflight_r & (occ_s == 2'd0);

endmodule

// File: tb/tb_fifo_bank_reader.sv
// Directed bench for fifo_bank_reader with a behavioural two-bank FIFO model.
module tb_fifo_bank_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bank0_empty, bank1_empty;
  logic [15:0] bank0_data, bank1_data;
  logic        bank0_rd, bank1_rd;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        m_bank;
  logic        drained;
  logic [31:0] word_count;

  always #5 clk = ~clk;

  fifo_bank_reader #(.DataWidth(16), .BufDepth(2), .CountWidth(32)) dut (
    .clk(clk), .rst(rst),
    .bank0_empty(bank0_empty), .bank1_empty(bank1_empty),
    .bank0_data(bank0_data), .bank1_data(bank1_data),
    .bank0_rd(bank0_rd), .bank1_rd(bank1_rd),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_bank(m_bank),
    .drained(drained), .word_count(word_count)
  );

  // Bank model: contents loaded all at once from staging arrays.
  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  logic [15:0] stage0 [16];
  logic [15:0] stage1 [16];
  int   stage_n0 = 0, stage_n1 = 0;
  logic load = 1'b0;
  int   cnt0 = 0, cnt1 = 0, ptr0 = 0, ptr1 = 0;
  int   rd0_count = 0, rd_empty_err = 0;

  assign bank0_empty = (cnt0 == 0);
  assign bank1_empty = (cnt1 == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= 0; cnt1 <= 0; ptr0 <= 0; ptr1 <= 0;
      bank0_data <= 16'h0000; bank1_data <= 16'h0000;
    end else if (load) begin
      for (int i = 0; i < 16; i++) begin
        mem0[i] <= stage0[i];
        mem1[i] <= stage1[i];
      end
      cnt0 <= stage_n0; cnt1 <= stage_n1; ptr0 <= 0; ptr1 <= 0;
    end else begin
      if (bank0_rd) begin
        rd0_count <= rd0_count + 1;
        if (cnt0 == 0) rd_empty_err <= rd_empty_err + 1;
        else begin
          bank0_data <= mem0[ptr0]; ptr0 <= ptr0 + 1; cnt0 <= cnt0 - 1;
        end
      end
      if (bank1_rd) begin
        if (cnt1 == 0) rd_empty_err <= rd_empty_err + 1;
        else begin
          bank1_data <= mem1[ptr1]; ptr1 <= ptr1 + 1; cnt1 <= cnt1 - 1;
        end
      end
    end
  end

  // Output monitor: logs accepted words and tracks buffered-plus-in-flight words.
  logic [16:0] got_mem [128];
  int got_n = 0, rd_total = 0, pop_total = 0, max_pending = 0, dual_err = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_total <= 0; pop_total <= 0;
    end else begin
      if (bank0_rd || bank1_rd) rd_total <= rd_total + 1;
      if (bank0_rd && bank1_rd) dual_err <= dual_err + 1;
      if (m_valid && m_ready) begin
        if (got_n < 128) got_mem[got_n] <= {m_bank, m_data};
        got_n     <= got_n + 1;
        pop_total <= pop_total + 1;
      end
      if ((rd_total + int'(bank0_rd || bank1_rd)) - (pop_total + int'(m_valid && m_ready)) > max_pending)
        max_pending <= (rd_total + int'(bank0_rd || bank1_rd)) - (pop_total + int'(m_valid && m_ready));
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic load_banks(input int n0, input logic [15:0] b0, input int n1, input logic [15:0] b1);
    for (int i = 0; i < 16; i++) begin
      stage0[i] = b0 + 16'(i);
      stage1[i] = b1 + 16'(i);
    end
    stage_n0 = n0; stage_n1 = n1;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic run_drain(input logic [7:0] pat, input int budget, input string tag);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      m_ready = pat[c % 8];
      step();
      if (drained) done = 1'b1;
    end
    check({tag, "_drained"}, 32'(drained), 32'd1);
  endtask

  task automatic check_words(input int start, input int n0, input logic [15:0] b0,
                             input int n1, input logic [15:0] b1, input string tag);
    logic [16:0] exp_w;
    check({tag, "_count"}, 32'(got_n - start), 32'(n0 + n1));
    for (int j = 0; j < n0 + n1; j++) begin
      if (j < n0) exp_w = {1'b0, b0 + 16'(j)};
      else        exp_w = {1'b1, b1 + 16'(j - n0)};
      if (start + j < got_n && start + j < 128)
        check($sformatf("%s_word%0d", tag, j), 32'(got_mem[start + j]), 32'(exp_w));
    end
  endtask

  typedef struct {
    int          n0;
    int          n1;
    logic [7:0]  pat;
    int          exp_words;
  } vec_t;

  vec_t        vecs [6];
  logic [7:0]  xr0, xr1, xv;
  logic [15:0] xd [8];
  logic [7:0]  xb;
  logic [31:0] wc_exp;
  int          start;
  bit          hit;
  logic [15:0] b0, b1;

  initial begin
    // Asynchronous reset in the middle of a clock phase.
    #3 rst = 1'b1;
    #1;
    check("rst_m_valid",  32'(m_valid),  32'd0);
    check("rst_m_data",   32'(m_data),   32'd0);
    check("rst_m_bank",   32'(m_bank),   32'd0);
    check("rst_rd",       32'({bank0_rd, bank1_rd}), 32'd0);
    check("rst_count",    word_count,    32'd0);
    check("rst_drained",  32'(drained),  32'd1);
    repeat (2) step();
    rst = 1'b0;
    step();
    wc_exp = 32'd0;

    // Bank0 only: empty falls -> m_valid three cycles later, one word per cycle.
    m_ready = 1'b1;
    xr0 = 8'h07; xv = 8'h1C;
    xd[2] = 16'h0001; xd[3] = 16'h0002; xd[4] = 16'h0003;
    load_banks(3, 16'h0001, 0, 16'h0000);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("lat_rd0_c%0d", k), 32'(bank0_rd), 32'(xr0[k-1]));
      check($sformatf("lat_valid_c%0d", k), 32'(m_valid), 32'(xv[k-1]));
      if (xv[k-1]) check($sformatf("lat_data_c%0d", k), 32'({m_bank, m_data}), 32'({1'b0, xd[k-1]}));
    end
    wc_exp += 32'd3;
    check("lat_count", word_count, wc_exp);
    check("lat_drained", 32'(drained), 32'd1);

    // Crossover: one idle read cycle at the bank switch, one bubble on the output.
    xr0 = 8'h03; xr1 = 8'h18; xv = 8'h6C; xb = 8'h60;
    xd[2] = 16'h00A0; xd[3] = 16'h00A1; xd[5] = 16'h00B0; xd[6] = 16'h00B1;
    load_banks(2, 16'h00A0, 2, 16'h00B0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("x_rd_c%0d", k), 32'({bank0_rd, bank1_rd}), 32'({xr0[k-1], xr1[k-1]}));
      check($sformatf("x_valid_c%0d", k), 32'(m_valid), 32'(xv[k-1]));
      if (xv[k-1]) check($sformatf("x_data_c%0d", k), 32'({m_bank, m_data}), 32'({xb[k-1], xd[k-1]}));
    end
    wc_exp += 32'd4;
    check("x_count", word_count, wc_exp);

    // Backpressure: two reads fill the buffer, head holds until released.
    m_ready = 1'b0;
    start = got_n;
    hit = 1'b0;
    load_banks(5, 16'h0C00, 0, 16'h0000);
    begin
      int rd_base;
      rd_base = rd0_count;
      for (int k = 1; k <= 6; k++) begin
        step();
        if (k >= 3) begin
          check($sformatf("bp_valid_c%0d", k), 32'(m_valid), 32'd1);
          check($sformatf("bp_head_c%0d", k), 32'({m_bank, m_data}), 32'({1'b0, 16'h0C00}));
        end
      end
      check("bp_reads", 32'(rd0_count - rd_base), 32'd2);
    end
    run_drain(8'hFF, 40, "bp");
    check_words(start, 5, 16'h0C00, 0, 16'h0000, "bp");
    wc_exp += 32'd5;
    check("bp_count", word_count, wc_exp);

    // Table-driven drains under assorted ready patterns.
    vecs[0] = '{n0: 3, n1: 0, pat: 8'hFF, exp_words: 3};
    vecs[1] = '{n0: 2, n1: 2, pat: 8'hFF, exp_words: 4};
    vecs[2] = '{n0: 0, n1: 3, pat: 8'hFF, exp_words: 3};
    vecs[3] = '{n0: 5, n1: 0, pat: 8'hAA, exp_words: 5};
    vecs[4] = '{n0: 4, n1: 4, pat: 8'h55, exp_words: 8};
    vecs[5] = '{n0: 1, n1: 1, pat: 8'h93, exp_words: 2};
    for (int v = 0; v < 6; v++) begin
      b0 = 16'h1000 + 16'(v * 16'h0100);
      b1 = 16'h2000 + 16'(v * 16'h0100);
      start = got_n;
      load_banks(vecs[v].n0, b0, vecs[v].n1, b1);
      run_drain(vecs[v].pat, 80, $sformatf("v%0d", v));
      check_words(start, vecs[v].n0, b0, vecs[v].n1, b1, $sformatf("v%0d", v));
      wc_exp += 32'(vecs[v].exp_words);
      check($sformatf("v%0d_wcount", v), word_count, wc_exp);
    end

    check("no_dual_strobe", 32'(dual_err), 32'd0);
    check("no_rd_on_empty", 32'(rd_empty_err), 32'd0);
    check("pending_le_2", 32'(max_pending <= 2), 32'd1);

    // Reset after two of four words are out: everything clears at once.
    m_ready = 1'b1;
    load_banks(4, 16'h0D00, 0, 16'h0000);
    for (int c = 0; c < 30 && !hit; c++) begin
      step();
      if (word_count == wc_exp + 32'd2) hit = 1'b1;
    end
    check("mid_reached_2", word_count, wc_exp + 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_valid", 32'(m_valid), 32'd0);
    check("mid_count", word_count, 32'd0);
    check("mid_rd", 32'({bank0_rd, bank1_rd}), 32'd0);
    check("mid_drained", 32'(drained), 32'd1);
    #2 rst = 1'b0;

    // Restart from IDLE with the usual three-cycle latency.
    start = got_n;
    load_banks(2, 16'h0E00, 0, 16'h0000);
    step(); step();
    check("re_valid_c2", 32'(m_valid), 32'd0);
    step();
    check("re_valid_c3", 32'(m_valid), 32'd1);
    check("re_data_c3", 32'({m_bank, m_data}), 32'({1'b0, 16'h0E00}));
    run_drain(8'hFF, 20, "re");
    check_words(start, 2, 16'h0E00, 0, 16'h0000, "re");
    check("re_count", word_count, 32'd2);
    check("re_no_rd_on_empty", 32'(rd_empty_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
